// File: rtl/inst_buffer_if.sv
// Fetch-to-decode bundle for the instruction buffer.
// The master modport drives fetch packets, decode backpressure and flush.
interface inst_buffer_if #(
    parameter int FETCH_WIDTH  = 4,
    parameter int DECODE_WIDTH = 4,
    parameter int DEPTH        = 16,
    parameter int XLEN         = 32
);
    localparam int NW = $clog2(FETCH_WIDTH + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic                         in_valid;
    logic [NW-1:0]                in_num;
    logic [FETCH_WIDTH*32-1:0]    in_inst;
    logic [FETCH_WIDTH*XLEN-1:0]  in_pc;
    logic                         in_ready;
    logic [DECODE_WIDTH-1:0]      out_valid;
    logic [DECODE_WIDTH*32-1:0]   out_inst;
    logic [DECODE_WIDTH*XLEN-1:0] out_pc;
    logic                         dec_ready;
    logic                         flush;
    logic [CW-1:0]                count;

    modport master (
        output in_valid, in_num, in_inst, in_pc, dec_ready, flush,
        input  in_ready, out_valid, out_inst, out_pc, count
    );

    modport slave (
        input  in_valid, in_num, in_inst, in_pc, dec_ready, flush,
        output in_ready, out_valid, out_inst, out_pc, count
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and the decode slots.
// Accepts up to FETCH_WIDTH words per cycle, presents up to DECODE_WIDTH.
module inst_buffer #(
    parameter int FETCH_WIDTH  = 4,
    parameter int DECODE_WIDTH = 4,
    parameter int DEPTH        = 16,
    parameter int XLEN         = 32
) (
    input logic         clk,
    input logic         rst,
    inst_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(FETCH_WIDTH + 1);

    logic [31:0]     inst_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count_q;

    logic            in_ready;
    logic            push;
    logic [CW-1:0]   nadd;
    logic [CW-1:0]   npop;

    // Space check uses registered occupancy only, so fetch never sees decode timing.
    assign in_ready  = (CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH);
    assign bus.in_ready = in_ready;
    assign bus.count    = count_q;

    always_comb begin
        push = bus.in_valid & in_ready & ~bus.flush & ~rst
             & (bus.in_num != '0);
        nadd = push ? CW'(bus.in_num) : '0;
        npop = '0;
        if (bus.dec_ready && !bus.flush) begin
            npop = (count_q < CW'(DECODE_WIDTH)) ? count_q
                                                 : CW'(DECODE_WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (NW'(i) < bus.in_num) begin
                    inst_q[tail + PW'(i)] <= bus.in_inst[32*i +: 32];
                    pc_q[tail + PW'(i)]   <= bus.in_pc[XLEN*i +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PW'(npop);
            tail    <= tail + PW'(nadd);
            count_q <= count_q + nadd - npop;
        end
    end

    always_comb begin
        bus.out_valid = '0;
        bus.out_inst  = '0;
        bus.out_pc    = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (CW'(i) < count_q) begin
                bus.out_valid[i]              = 1'b1;
                bus.out_inst[32*i +: 32]      = inst_q[head + PW'(i)];
                bus.out_pc[XLEN*i +: XLEN]    = pc_q[head + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus.in_valid) begin
                assert (bus.in_num != '0 && bus.in_num <= NW'(FETCH_WIDTH))
                    else $error("in_num out of range");
            end
            assert (count_q <= CW'(DEPTH))
                else $error("count overflow");
            assert ((bus.out_valid
                     & (bus.out_valid + DECODE_WIDTH'(1))) == '0)
                else $error("out_valid not contiguous");
            assert (npop <= count_q)
                else $error("pop exceeds count");
        end
    end
endmodule
